// File: rtl/johnson_step_ctrl_pkg.sv
// Shared types and helpers for the Johnson-ring step sequencer.
// The FSM state encoding, the direction constants and the ring-legality check live here.
package johnson_step_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic FWD = 1'b1;
  localparam logic REV = 1'b0;

  // A legal Johnson value, XOR-folded with its MSB, is a run of ones from
  // the LSB upward. Any 0 below a 1 means a second boundary, so the value is illegal.
  function automatic logic johnson_legal(input logic [31:0] v, input int unsigned w);
    logic ok;
    logic msb;
    ok  = 1'b1;
    msb = v[w-1];
    for (int i = 1; i < 32; i++) begin
      if (i < int'(w)) begin
        if ((v[i] ^ msb) && !(v[i-1] ^ msb)) ok = 1'b0;
      end
    end
    return ok;
  endfunction

endpackage

// File: rtl/johnson_step_ctrl_if.sv
// Command and status bundle between a move requester and the step sequencer.
interface johnson_step_ctrl_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8,
  parameter int DIV_W = 16
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_dir;
  logic [CNT_W-1:0] cmd_steps;
  logic [DIV_W-1:0] cmd_div;
  logic             abort;
  logic [WIDTH-1:0] phase;
  logic             busy;
  logic             done;
  logic             aborted;
  logic [CNT_W-1:0] steps_left;
  logic             fault;

  modport master (
    output cmd_valid, cmd_dir, cmd_steps, cmd_div, abort,
    input  cmd_ready, phase, busy, done, aborted, steps_left, fault
  );

  modport slave (
    input  cmd_valid, cmd_dir, cmd_steps, cmd_div, abort,
    output cmd_ready, phase, busy, done, aborted, steps_left, fault
  );
endinterface

// File: rtl/johnson_step_ctrl_ring.sv
// Johnson ring register: steps forward or reverse on enable, with a synchronous clear to zero.
module johnson_ring_core
  import johnson_step_ctrl_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step_i,
  input  logic             dir_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] phase_o
);

  logic [WIDTH-1:0] phase_q;

  // NOTE: sequential state is written with non-blocking assignments only, so every
  // flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q <= '0;
    end else if (clr_i) begin
      phase_q <= '0;
    end else if (step_i) begin
      if (dir_i == FWD) phase_q <= {phase_q[WIDTH-2:0], ~phase_q[WIDTH-1]};
      else              phase_q <= {~phase_q[0], phase_q[WIDTH-1:1]};
    end
  end

  assign phase_o = phase_q;

endmodule

// File: rtl/johnson_step_ctrl.sv
// Move sequencer: accepts one command, paces ring steps by a divider and reports progress.
// It also handles abort and recovers the ring from illegal states.
module johnson_step_ctrl
  import johnson_step_ctrl_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8,
  parameter int DIV_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  johnson_step_ctrl_if.slave  bus
);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_RUN  = RUN;
  localparam logic [1:0] ST_DONE = DONE;

  logic [1:0]       state_q, state_d;
  logic             dir_q, dir_d;
  logic [DIV_W-1:0] interval_q, interval_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] steps_q, steps_d;
  logic             fault_q, fault_d;
  logic             aborted_q, aborted_d;

  logic [WIDTH-1:0] phase;
  logic [DIV_W-1:0] cmd_interval;
  logic             illegal;
  logic             step_en;

  assign illegal      = !johnson_legal(32'(phase), WIDTH);
  assign cmd_interval = (bus.cmd_div == '0) ? DIV_W'(1) : bus.cmd_div;

  johnson_ring_core #(.WIDTH(WIDTH)) u_ring (
    .clk     (clk),
    .rst     (rst),
    .step_i  (step_en),
    .dir_i   (dir_q),
    .clr_i   (illegal),
    .phase_o (phase)
  );

  // NOTE: every next-state signal takes its hold value first, so no path through
  // the case statement leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    interval_d = interval_q;
    div_d      = div_q;
    steps_d    = steps_q;
    fault_d    = fault_q;
    aborted_d  = aborted_q;
    step_en    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          dir_d      = bus.cmd_dir;
          interval_d = cmd_interval;
          steps_d    = bus.cmd_steps;
          fault_d    = 1'b0;
          aborted_d  = 1'b0;
          if (bus.cmd_steps == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
            div_d   = cmd_interval - DIV_W'(1);
          end
        end
      end
      ST_RUN: begin
        // Abort wins over a step falling due on the same edge.
        if (bus.abort) begin
          state_d   = ST_DONE;
          aborted_d = 1'b1;
        end else if (div_q != '0) begin
          div_d = div_q - DIV_W'(1);
        end else begin
          div_d = interval_q - DIV_W'(1);
          if (!illegal && steps_q != '0) begin
            step_en = 1'b1;
            steps_d = steps_q - CNT_W'(1);
            if (steps_q == CNT_W'(1)) state_d = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // The ring clear on an illegal value is sticky-flagged until the next accept.
    if (illegal) fault_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      dir_q      <= FWD;
      interval_q <= DIV_W'(1);
      div_q      <= '0;
      steps_q    <= '0;
      fault_q    <= 1'b0;
      aborted_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      interval_q <= interval_d;
      div_q      <= div_d;
      steps_q    <= steps_d;
      fault_q    <= fault_d;
      aborted_q  <= aborted_d;
    end
  end

  assign bus.cmd_ready  = (state_q == ST_IDLE);
  assign bus.busy       = (state_q == ST_RUN);
  assign bus.done       = (state_q == ST_DONE);
  assign bus.aborted    = aborted_q;
  assign bus.steps_left = steps_q;
  assign bus.fault      = fault_q;
  assign bus.phase      = phase;

endmodule

// File: tb/tb_johnson_step_ctrl.sv
// Self-checking bench for johnson_step_ctrl: directed moves and random moves.
// Expected values come from a ring-position model indexed 0..2*WIDTH-1.
module tb_johnson_step_ctrl;
  import johnson_step_ctrl_pkg::*;

  localparam int WIDTH = 4;
  localparam int CNT_W = 8;
  localparam int DIV_W = 16;
  localparam int NST   = 2 * WIDTH;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  johnson_step_ctrl_if #(.WIDTH(WIDTH), .CNT_W(CNT_W), .DIV_W(DIV_W)) bus ();

  johnson_step_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W), .DIV_W(DIV_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  int idx         = 0;

  // Ring position k: k ones filling from the LSB, then zeros filling from the LSB.
  function automatic logic [WIDTH-1:0] ring_val(input int k);
    logic [31:0] v;
    if (k <= WIDTH) v = (32'd1 << k) - 32'd1;
    else            v = ((32'd1 << WIDTH) - 32'd1) & ~((32'd1 << (k - WIDTH)) - 32'd1);
    return v[WIDTH-1:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (bus.cmd_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", 32'(bus.cmd_ready), 32'd1);
  endtask

  task automatic accept(input logic dir, input int steps, input int div);
    wait_ready();
    bus.cmd_valid = 1'b1;
    bus.cmd_dir   = dir;
    bus.cmd_steps = CNT_W'(steps);
    bus.cmd_div   = DIV_W'(div);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    check("fault_clr", 32'(bus.fault), 32'd0);
  endtask

  task automatic step_model(input logic dir);
    idx = dir ? (idx + 1) % NST : (idx + NST - 1) % NST;
  endtask

  task automatic run_move(input logic dir, input int steps, input int div, input int abort_at);
    int iv;
    int left;
    iv   = (div == 0) ? 1 : div;
    left = steps;
    accept(dir, steps, div);
    if (steps == 0) begin
      check("zero_done", 32'(bus.done), 32'd1);
      check("zero_busy", 32'(bus.busy), 32'd0);
      check("zero_phase", 32'(bus.phase), 32'(ring_val(idx)));
      check("zero_abt", 32'(bus.aborted), 32'd0);
      @(posedge clk);
      #1;
      check("zero_ready", 32'(bus.cmd_ready), 32'd1);
      check("zero_done_end", 32'(bus.done), 32'd0);
      return;
    end
    check("acc_busy", 32'(bus.busy), 32'd1);
    check("acc_ready", 32'(bus.cmd_ready), 32'd0);
    check("acc_left", 32'(bus.steps_left), 32'(steps));
    for (int e = 1; e <= steps * iv; e++) begin
      if (e == abort_at) bus.abort = 1'b1;
      @(posedge clk);
      #1;
      bus.abort = 1'b0;
      if (e == abort_at) begin
        check("abt_phase", 32'(bus.phase), 32'(ring_val(idx)));
        check("abt_left", 32'(bus.steps_left), 32'(left));
        check("abt_done", 32'(bus.done), 32'd1);
        check("abt_flag", 32'(bus.aborted), 32'd1);
        check("abt_busy", 32'(bus.busy), 32'd0);
        return;
      end
      if (e % iv == 0) begin
        step_model(dir);
        left--;
      end
      check("run_phase", 32'(bus.phase), 32'(ring_val(idx)));
      check("run_left", 32'(bus.steps_left), 32'(left));
      if (left == 0) begin
        check("end_done", 32'(bus.done), 32'd1);
        check("end_abt", 32'(bus.aborted), 32'd0);
        check("end_busy", 32'(bus.busy), 32'd0);
      end else begin
        check("run_busy", 32'(bus.busy), 32'd1);
        check("run_done", 32'(bus.done), 32'd0);
      end
    end
    @(posedge clk);
    #1;
    check("post_ready", 32'(bus.cmd_ready), 32'd1);
    check("post_done", 32'(bus.done), 32'd0);
  endtask

  initial begin
    int r_steps, r_div, r_iv, r_abort;
    logic r_dir;

    rst           = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_dir   = 1'b0;
    bus.cmd_steps = '0;
    bus.cmd_div   = '0;
    bus.abort     = 1'b0;
    #12;
    check("rst_phase", 32'(bus.phase), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_left", 32'(bus.steps_left), 32'd0);
    check("rst_fault", 32'(bus.fault), 32'd0);
    check("rst_abt", 32'(bus.aborted), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_ready", 32'(bus.cmd_ready), 32'd1);

    run_move(FWD, 8, 1, 0);
    check("full_cycle_phase", 32'(bus.phase), 32'h0);
    run_move(REV, 3, 4, 0);
    check("rev_phase", 32'(bus.phase), 32'hE);
    run_move(FWD, 3, 1, 0);
    run_move(FWD, 0, 5, 0);
    run_move(FWD, 10, 2, 8);
    check("abt_phase7", 32'(bus.phase), 32'h7);
    check("abt_left7", 32'(bus.steps_left), 32'd7);

    // Corrupt the ring mid-move; the next edge must clear it and raise fault.
    accept(FWD, 6, 1);
    for (int e = 0; e < 2; e++) begin
      @(posedge clk);
      #1;
      step_model(FWD);
      check("flt_pre_phase", 32'(bus.phase), 32'(ring_val(idx)));
    end
    force dut.u_ring.phase_q = 4'b0101;
    #1;
    release dut.u_ring.phase_q;
    @(posedge clk);
    #1;
    idx = 0;
    check("flt_phase", 32'(bus.phase), 32'd0);
    check("flt_flag", 32'(bus.fault), 32'd1);
    check("flt_left", 32'(bus.steps_left), 32'd4);
    for (int e = 0; e < 4; e++) begin
      @(posedge clk);
      #1;
      step_model(FWD);
      check("flt_resume", 32'(bus.phase), 32'(ring_val(idx)));
    end
    check("flt_done", 32'(bus.done), 32'd1);
    check("flt_sticky", 32'(bus.fault), 32'd1);
    run_move(REV, 2, 1, 0);

    // Reset in the middle of a long move.
    accept(FWD, 20, 1);
    for (int e = 0; e < 5; e++) begin
      @(posedge clk);
      #1;
      step_model(FWD);
      check("pre_rst_phase", 32'(bus.phase), 32'(ring_val(idx)));
    end
    rst = 1'b0;
    #1;
    idx = 0;
    check("mid_rst_phase", 32'(bus.phase), 32'd0);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_done", 32'(bus.done), 32'd0);
    check("mid_rst_left", 32'(bus.steps_left), 32'd0);
    @(posedge clk);
    #1;
    check("mid_rst_nodone", 32'(bus.done), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("post_rst_ready", 32'(bus.cmd_ready), 32'd1);
    run_move(FWD, 4, 3, 0);

    for (int n = 0; n < 10; n++) begin
      r_dir   = 1'($urandom % 2);
      r_steps = int'($urandom_range(0, 12));
      r_div   = int'($urandom_range(0, 4));
      r_iv    = (r_div == 0) ? 1 : r_div;
      r_abort = 0;
      if (r_steps > 0 && ($urandom % 3) == 0) r_abort = int'($urandom_range(1, r_steps * r_iv));
      run_move(r_dir, r_steps, r_div, r_abort);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
